// File: rtl/hxm_ssid_write_scheduler_if.sv
// Request/HNM bundle for the SSID write scheduler.
// The slave modport is the scheduler's view. The master modport is the view of the
// environment: the SSID sources and the HNM.
interface hxm_ssid_write_scheduler_if #(
  parameter int SSIDBITS = 8,
  parameter int NREQ     = 4
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*SSIDBITS-1:0] req_ssid;
  logic [NREQ-1:0]          req_ready;
  logic                     hnm_write_ready;
  logic                     hnm_new_output;
  logic                     hnm_write;
  logic [SSIDBITS-1:0]      hnm_ssid;
  logic                     hnm_reset;

  modport slave (
    input  req_valid, req_ssid, hnm_write_ready, hnm_new_output,
    output req_ready, hnm_write, hnm_ssid, hnm_reset
  );

  modport master (
    output req_valid, req_ssid, hnm_write_ready, hnm_new_output,
    input  req_ready, hnm_write, hnm_ssid, hnm_reset
  );
endinterface

// File: rtl/hxm_ssid_write_scheduler.sv
// Round-robin scheduler that shares the single HNM SSID write port among NREQ sources.
// For each event it holds the HNM in reset, accepts SSIDs, and tracks writes in flight
// until the HNM returns them on newOutput. It then drains and pulses done.
// Optional feature: define HXM_SCHED_STATS_EN to add per-requester grant counters (stat_grants).
module hxm_ssid_write_scheduler #(
  parameter int SSIDBITS     = 8,
  parameter int NREQ         = 4,
  parameter int MAX_INFLIGHT = 15,
  parameter int INFLIGHTBITS = 4,
  parameter int RESET_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    flush,
  input  logic                    clear,
  hxm_ssid_write_scheduler_if.slave bus,
  output logic [INFLIGHTBITS-1:0] in_flight,
  output logic                    idle,
  output logic                    done,
  output logic                    err_underflow
`ifdef HXM_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]      stat_grants
`endif
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [1:0] {INIT, IDLE, RUN, DRAIN} state_t;

  state_t                  state, state_next;
  logic [CNTW-1:0]         init_cnt, cnt_next;
  logic [PTRW-1:0]         rr_ptr;
  logic [PTRW-1:0]         gnt_idx;
  logic                    gnt_found;
  logic                    grant;
  logic                    done_next;
  logic [NREQ-1:0]         ready;
  logic [INFLIGHTBITS:0]   pending;
  logic                    write_p1;
  logic [SSIDBITS-1:0]     ssid_p1;
  logic                    hnm_reset_p1;

  assign bus.req_ready = ready;
  assign bus.hnm_write = write_p1;
  assign bus.hnm_ssid  = ssid_p1;
  assign bus.hnm_reset = hnm_reset_p1;
  assign idle          = (state == IDLE);

  // Next-state, round-robin arbitration and grant gating
  always_comb begin
    state_next = state;
    cnt_next   = init_cnt;
    done_next  = 1'b0;
    grant      = 1'b0;
    gnt_found  = 1'b0;
    gnt_idx    = '0;
    ready      = '0;
    // A strobe on the port now is counted next edge, so include it in the budget
    pending    = {1'b0, in_flight} + {{INFLIGHTBITS{1'b0}}, write_p1};

    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_found && bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTRW'((int'(rr_ptr) + k) % NREQ);
      end
    end

    unique case (state)
      INIT: begin
        if (init_cnt == CNTW'(RESET_CYCLES - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = init_cnt + CNTW'(1);
        end
      end
      IDLE: begin
        if (clear) begin
          state_next = INIT;
          cnt_next   = '0;
        end else if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        grant = gnt_found && bus.hnm_write_ready &&
                (pending < (INFLIGHTBITS+1)'(MAX_INFLIGHT));
        if (flush) state_next = DRAIN;
      end
      DRAIN: begin
        if (in_flight == '0 && !write_p1) begin
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = INIT;
    endcase

    if (grant) ready[gnt_idx] = 1'b1;
  end

  // State register, HNM reset output and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= INIT;
      init_cnt     <= '0;
      hnm_reset_p1 <= 1'b1;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      init_cnt     <= cnt_next;
      hnm_reset_p1 <= (state_next == INIT);
      done         <= done_next;
    end
  end

  // Grant -> registered HNM write strobe and SSID, round-robin pointer advance
  always_ff @(posedge clk) begin
    if (reset) begin
      write_p1 <= 1'b0;
      ssid_p1  <= '0;
      rr_ptr   <= '0;
    end else begin
      write_p1 <= grant;
      if (grant) begin
        ssid_p1 <= bus.req_ssid[int'(gnt_idx)*SSIDBITS +: SSIDBITS];
        rr_ptr  <= (gnt_idx == PTRW'(NREQ - 1)) ? '0 : gnt_idx + PTRW'(1);
      end
    end
  end

  // In-flight accounting; the HNM is held in reset during INIT, so nothing there is counted
  always_ff @(posedge clk) begin
    if (reset || state == INIT) begin
      in_flight <= '0;
    end else begin
      unique case ({write_p1, bus.hnm_new_output})
        2'b10:   in_flight <= in_flight + INFLIGHTBITS'(1);
        2'b01:   if (in_flight != '0) in_flight <= in_flight - INFLIGHTBITS'(1);
        default: ;
      endcase
    end
  end

  // Sticky flag: newOutput arrived with nothing outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      err_underflow <= 1'b0;
    end else if (state != INIT && bus.hnm_new_output && !write_p1 && in_flight == '0) begin
      err_underflow <= 1'b1;
    end
  end

`ifdef HXM_SCHED_STATS_EN
  // Per-requester saturating accepted-SSID counters, cleared while the HNM is reset
  always_ff @(posedge clk) begin
    if (reset || state == INIT) begin
      stat_grants <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (ready[i] && bus.req_valid[i] && stat_grants[i*16 +: 16] != 16'hFFFF)
          stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
